// File: rtl/instr_fetch.sv
// Fetch stage: PC register, credit-based requests to a 1-cycle synchronous
// instruction memory, 2-entry response FIFO, valid/ready hand-off to decode.
module instr_fetch #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        im_req,
    output logic [31:0] im_addr,
    input  logic [31:0] im_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc
);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } if_entry_t;

    logic [31:0]          pc;
    if_entry_t [1:0]      fifo;
    logic                 rd_ptr;
    logic                 wr_ptr;
    logic [1:0]           occ;
    logic                 inflight;
    logic [31:0]          inflight_pc;
    logic                 drop;

    logic                 pop;
    logic                 push;
    logic [2:0]           slots_used;
    logic                 unused_pc_bits;

    // Low address bits of a redirect target carry no meaning for word fetch.
    assign unused_pc_bits = ^redirect_pc[1:0];

    // Handshake, credit check and response acceptance.
    always_comb begin
        pop        = if_valid & if_ready;
        push       = inflight & ~drop & ~redirect_valid;
        // Slots that will be held next cycle: occupied + in flight - leaving.
        slots_used = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
        // Held low during reset so the memory sees no request before release.
        im_req     = reset_n & ~redirect_valid & (slots_used < 3'd2);
        im_addr    = pc;
        if_valid   = (occ != 2'd0);
        if_instr   = fifo[rd_ptr].instr;
        if_pc      = fifo[rd_ptr].pc;
    end

    // PC and outstanding-request tracking; redirect overrides sequential fetch.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc          <= {PC_RESET[31:2], 2'b00};
            inflight    <= 1'b0;
            inflight_pc <= '0;
            drop        <= 1'b0;
        end else begin
            inflight <= im_req;
            // A response landing just after a redirect belongs to the old path.
            drop     <= redirect_valid & inflight;
            if (redirect_valid) begin
                pc <= {redirect_pc[31:2], 2'b00};
            end else if (im_req) begin
                pc          <= pc + 32'd4;
                inflight_pc <= pc;
            end
        end
    end

    // Response FIFO; a redirect empties it regardless of push/pop this cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fifo   <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            occ    <= 2'd0;
        end else if (redirect_valid) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            occ    <= 2'd0;
        end else begin
            if (push) begin
                fifo[wr_ptr] <= '{pc: inflight_pc, instr: im_rdata};
                wr_ptr       <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

    // The credit rule must never let a response arrive with both slots full.
    a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
        !(push && occ == 2'd2));

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: memory returns addr>>2, expected values
// are hand-derived from the request/response timing.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        im_req, im_req2;
    logic [31:0] im_addr, im_addr2;
    logic [31:0] im_rdata = '0, im_rdata2 = '0;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid, if_valid2;
    logic        if_ready;
    logic [31:0] if_instr, if_instr2;
    logic [31:0] if_pc, if_pc2;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    instr_fetch dut (
        .clk(clk), .reset_n(reset_n),
        .im_req(im_req), .im_addr(im_addr), .im_rdata(im_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_valid(if_valid), .if_ready(if_ready),
        .if_instr(if_instr), .if_pc(if_pc)
    );

    // Second instance exercises PC wrap from the top of the address space.
    instr_fetch #(.PC_RESET(32'hFFFF_FFF8)) dut_wrap (
        .clk(clk), .reset_n(reset_n),
        .im_req(im_req2), .im_addr(im_addr2), .im_rdata(im_rdata2),
        .redirect_valid(1'b0), .redirect_pc(32'h0),
        .if_valid(if_valid2), .if_ready(1'b1),
        .if_instr(if_instr2), .if_pc(if_pc2)
    );

    // Synchronous memories with fixed 1-cycle latency, data = word index.
    always @(posedge clk) if (im_req)  im_rdata  <= im_addr  >> 2;
    always @(posedge clk) if (im_req2) im_rdata2 <= im_addr2 >> 2;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs change here.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] exp_pc;

        reset_n        = 1'b0;
        if_ready       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        repeat (3) next_cycle();

        #1;
        chk("rst_im_req",   {31'b0, im_req},   32'd0);
        chk("rst_im_addr",  im_addr,           32'h0000_3000);
        chk("rst_if_valid", {31'b0, if_valid}, 32'd0);
        chk("rst_if_instr", if_instr,          32'd0);
        chk("rst_if_pc",    if_pc,             32'd0);
        chk("rst_wrap_addr", im_addr2,         32'hFFFF_FFF8);

        // Streaming from reset: one request per cycle, first valid in cycle 2.
        next_cycle();
        reset_n  = 1'b1;
        if_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            #1;
            chk("str_im_req",  {31'b0, im_req}, 32'd1);
            chk("str_im_addr", im_addr, 32'h0000_3000 + 32'(4 * k));
            chk("str_valid",   {31'b0, if_valid}, (k >= 2) ? 32'd1 : 32'd0);
            chk("wrap_valid",  {31'b0, if_valid2}, (k >= 2) ? 32'd1 : 32'd0);
            if (k >= 2) begin
                exp_pc = 32'h0000_3000 + 32'(4 * (k - 2));
                chk("str_if_pc",    if_pc,    exp_pc);
                chk("str_if_instr", if_instr, exp_pc >> 2);
                exp_pc = 32'hFFFF_FFF8 + 32'(4 * (k - 2));
                chk("wrap_if_pc",    if_pc2,    exp_pc);
                chk("wrap_if_instr", if_instr2, exp_pc >> 2);
            end
            next_cycle();
        end

        // Redirect while a request is in flight: its word must never show.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_4007;
        #1;
        chk("rd_im_req", {31'b0, im_req}, 32'd0);
        next_cycle();
        redirect_valid = 1'b0;
        #1;
        chk("rd1_valid", {31'b0, if_valid}, 32'd0);
        chk("rd1_addr",  im_addr, 32'h0000_4004);
        chk("rd1_req",   {31'b0, im_req}, 32'd1);
        next_cycle();
        #1;
        chk("rd2_valid", {31'b0, if_valid}, 32'd0);
        chk("rd2_addr",  im_addr, 32'h0000_4008);
        next_cycle();
        #1;
        chk("rd3_valid", {31'b0, if_valid}, 32'd1);
        chk("rd3_pc",    if_pc,    32'h0000_4004);
        chk("rd3_instr", if_instr, 32'h0000_1001);
        next_cycle();
        #1;
        chk("rd4_pc",    if_pc,    32'h0000_4008);
        chk("rd4_instr", if_instr, 32'h0000_1002);

        // Stall to fill the FIFO (head 4008, 400C behind it).
        if_ready = 1'b0;
        #1;
        chk("stl_req0", {31'b0, im_req}, 32'd0);
        next_cycle();
        #1;
        chk("stl_req1", {31'b0, im_req}, 32'd0);
        chk("stl_pc1",  if_pc, 32'h0000_4008);
        next_cycle();
        #1;
        chk("stl_addr", im_addr, 32'h0000_4010);
        chk("stl_pc2",  if_pc,   32'h0000_4008);

        // Redirect with a full FIFO and decode ready: old entries vanish.
        if_ready       = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_5000;
        #1;
        chk("rf_im_req", {31'b0, im_req}, 32'd0);
        next_cycle();
        redirect_valid = 1'b0;
        #1;
        chk("rf1_valid", {31'b0, if_valid}, 32'd0);
        chk("rf1_addr",  im_addr, 32'h0000_5000);
        next_cycle();
        #1;
        chk("rf2_valid", {31'b0, if_valid}, 32'd0);
        next_cycle();
        #1;
        chk("rf3_pc",    if_pc,    32'h0000_5000);
        chk("rf3_instr", if_instr, 32'h0000_1400);
        next_cycle();
        #1;
        chk("rf4_pc",    if_pc,    32'h0000_5004);

        // Back-to-back redirects: only the second target is fetched.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_6000;
        next_cycle();
        redirect_pc    = 32'h0000_7000;
        next_cycle();
        redirect_valid = 1'b0;
        #1;
        chk("bb1_valid", {31'b0, if_valid}, 32'd0);
        chk("bb1_addr",  im_addr, 32'h0000_7000);
        chk("bb1_req",   {31'b0, im_req}, 32'd1);
        next_cycle();
        #1;
        chk("bb2_valid", {31'b0, if_valid}, 32'd0);
        next_cycle();
        #1;
        chk("bb3_pc",    if_pc,    32'h0000_7000);
        chk("bb3_instr", if_instr, 32'h0000_1C00);

        // Fresh reset with decode stalled from the start.
        next_cycle();
        reset_n  = 1'b0;
        if_ready = 1'b0;
        next_cycle();
        reset_n  = 1'b1;
        for (int k = 0; k < 7; k++) begin
            #1;
            chk("hold_req",   {31'b0, im_req}, (k < 2) ? 32'd1 : 32'd0);
            chk("hold_addr",  im_addr, (k < 2) ? 32'h0000_3000 + 32'(4 * k) : 32'h0000_3008);
            chk("hold_valid", {31'b0, if_valid}, (k >= 2) ? 32'd1 : 32'd0);
            if (k >= 2) chk("hold_head", if_pc, 32'h0000_3000);
            next_cycle();
        end
        if_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            exp_pc = 32'h0000_3000 + 32'(4 * k);
            chk("rel_valid", {31'b0, if_valid}, 32'd1);
            chk("rel_pc",    if_pc,    exp_pc);
            chk("rel_instr", if_instr, exp_pc >> 2);
            next_cycle();
        end

        // Asynchronous reset between clock edges.
        #2;
        reset_n = 1'b0;
        #1;
        chk("ar_valid", {31'b0, if_valid}, 32'd0);
        chk("ar_req",   {31'b0, im_req},   32'd0);
        chk("ar_addr",  im_addr,  32'h0000_3000);
        chk("ar_pc",    if_pc,    32'd0);
        chk("ar_instr", if_instr, 32'd0);
        next_cycle();
        reset_n = 1'b1;
        #1;
        chk("ar0_addr", im_addr, 32'h0000_3000);
        chk("ar0_req",  {31'b0, im_req}, 32'd1);
        next_cycle();
        next_cycle();
        #1;
        chk("ar2_pc",    if_pc,    32'h0000_3000);
        chk("ar2_instr", if_instr, 32'h0000_0C00);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
